// File: rtl/sseg_scan_capture.sv
// Loopback capture of the multiplexed seven-segment drive.
// Rebuilds eight hex digits and decimal points; publishes once per full scan.
module sseg_scan_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 400_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  D1_AN,
    input  logic [3:0]  D2_AN,
    input  logic [7:0]  D1_SEG,
    input  logic [7:0]  D2_SEG,
    output logic [31:0] hex_val,
    output logic [7:0]  hex_ok,
    output logic [7:0]  dpoints,
    output logic        frame_valid,
    output logic        frame_pulse,
    output logic        an_error,
    output logic        stale
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [23:0] pins;
    logic [23:0] s1_q;
    logic [23:0] b_q;
    logic [23:0] prev_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] to_q;

    logic [3:0] an1;
    logic [3:0] an2;
    logic [7:0] sg1;
    logic [7:0] sg2;

    logic       strobe;
    logic       an_valid;
    logic       an_blank;
    logic [1:0] idx;
    logic       cap;
    logic       illegal;
    logic       publish;
    logic [4:0] dec_lo;
    logic [4:0] dec_hi;

    logic [7:0][3:0] sh_nib_q;
    logic [7:0][3:0] sh_nib_d;
    logic [7:0]      sh_ok_q;
    logic [7:0]      sh_ok_d;
    logic [7:0]      sh_dp_q;
    logic [7:0]      sh_dp_d;
    logic [3:0]      seen_q;
    logic [3:0]      seen_d;

    logic [31:0] hex_q;
    logic [7:0]  ok_q;
    logic [7:0]  dp_q;
    logic        fv_q;
    logic        pulse_q;
    logic        err_q;
    logic        stale_q;

    assign pins = {D1_AN, D2_AN, D1_SEG, D2_SEG};
    assign an1  = b_q[23:20];
    assign an2  = b_q[19:16];
    assign sg1  = b_q[15:8];
    assign sg2  = b_q[7:0];

    function automatic logic [4:0] glyph(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Counter passes SETTLE-1 here, so the window already spans SETTLE cycles.
    assign strobe = (b_q == prev_q) &&
                    (cnt_q == CW'(SETTLE_CYCLES - 2));

    always_comb begin
        an_valid = 1'b0;
        idx      = 2'd0;
        if (an1 == an2) begin
            case (an1)
                4'b1110: begin an_valid = 1'b1; idx = 2'd0; end
                4'b1101: begin an_valid = 1'b1; idx = 2'd1; end
                4'b1011: begin an_valid = 1'b1; idx = 2'd2; end
                4'b0111: begin an_valid = 1'b1; idx = 2'd3; end
                default: begin an_valid = 1'b0; idx = 2'd0; end
            endcase
        end
    end

    assign an_blank = (an1 == 4'hF) && (an2 == 4'hF);
    assign cap      = strobe && an_valid;
    assign illegal  = strobe && !an_valid && !an_blank;
    assign dec_lo   = glyph(~sg2[6:0]);
    assign dec_hi   = glyph(~sg1[6:0]);

    always_comb begin
        sh_nib_d = sh_nib_q;
        sh_ok_d  = sh_ok_q;
        sh_dp_d  = sh_dp_q;
        seen_d   = seen_q;
        if (cap) begin
            sh_nib_d[{1'b0, idx}] = dec_lo[3:0];
            sh_nib_d[{1'b1, idx}] = dec_hi[3:0];
            sh_ok_d[{1'b0, idx}]  = dec_lo[4];
            sh_ok_d[{1'b1, idx}]  = dec_hi[4];
            sh_dp_d[{1'b0, idx}]  = ~sg2[7];
            sh_dp_d[{1'b1, idx}]  = ~sg1[7];
            seen_d[idx]           = 1'b1;
        end
    end

    assign publish = cap && (seen_d == 4'hF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            b_q    <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= pins;
            b_q    <= s1_q;
            prev_q <= b_q;
            if (b_q != prev_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CW'(SETTLE_CYCLES)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_nib_q <= '0;
            sh_ok_q  <= '0;
            sh_dp_q  <= '0;
            seen_q   <= '0;
            to_q     <= '0;
            hex_q    <= '0;
            ok_q     <= '0;
            dp_q     <= '0;
            fv_q     <= 1'b0;
            pulse_q  <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            sh_nib_q <= sh_nib_d;
            sh_ok_q  <= sh_ok_d;
            sh_dp_q  <= sh_dp_d;
            pulse_q  <= publish;
            if (illegal) begin
                err_q <= 1'b1;
            end
            if (cap) begin
                to_q    <= '0;
                stale_q <= 1'b0;
                if (publish) begin
                    hex_q  <= sh_nib_d;
                    ok_q   <= sh_ok_d;
                    dp_q   <= sh_dp_d;
                    fv_q   <= 1'b1;
                    seen_q <= '0;
                end else begin
                    seen_q <= seen_d;
                end
            end else if (to_q != TW'(TIMEOUT_CYCLES)) begin
                to_q <= to_q + 1'b1;
                if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    stale_q <= 1'b1;
                    fv_q    <= 1'b0;
                    seen_q  <= '0;
                end
            end
        end
    end

    assign hex_val     = hex_q;
    assign hex_ok      = ok_q;
    assign dpoints     = dp_q;
    assign frame_valid = fv_q;
    assign frame_pulse = pulse_q;
    assign an_error    = err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture.
// Drives scan patterns on the falling edge and checks published frames.
module tb_sseg_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  d1_an;
    logic [3:0]  d2_an;
    logic [7:0]  d1_seg;
    logic [7:0]  d2_seg;
    logic [31:0] hex_val;
    logic [7:0]  hex_ok;
    logic [7:0]  dpoints;
    logic        frame_valid;
    logic        frame_pulse;
    logic        an_error;
    logic        stale;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int p0;

    logic [6:0] gl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    sseg_scan_capture #(
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .D1_AN      (d1_an),
        .D2_AN      (d2_an),
        .D1_SEG     (d1_seg),
        .D2_SEG     (d2_seg),
        .hex_val    (hex_val),
        .hex_ok     (hex_ok),
        .dpoints    (dpoints),
        .frame_valid(frame_valid),
        .frame_pulse(frame_pulse),
        .an_error   (an_error),
        .stale      (stale)
    );

    always @(posedge clk) begin
        #1;
        if (frame_pulse === 1'b1) pulses++;
    end

    function automatic logic [7:0] seg(input int d, input logic dp);
        return {~dp, ~gl[d]};
    endfunction

    function automatic logic [3:0] an(input int k);
        logic [3:0] a;
        a = 4'b0001 << k;
        return ~a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pos(input int k, input logic [7:0] s2,
                       input logic [7:0] s1, input int n);
        d1_an  = an(k);
        d2_an  = an(k);
        d2_seg = s2;
        d1_seg = s1;
        hold(n);
    endtask

    task automatic blank(input int n);
        d1_an = 4'hF;
        d2_an = 4'hF;
        hold(n);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hex"}, hex_val, 32'h0);
        chk({tag, "_okdp"}, {16'h0, hex_ok, dpoints}, 32'h0);
        chk({tag, "_flags"},
            {28'h0, frame_valid, frame_pulse, an_error, stale}, 32'h0);
    endtask

    initial begin
        reset  = 1'b1;
        d1_an  = 4'hF;
        d2_an  = 4'hF;
        d1_seg = 8'hFF;
        d2_seg = 8'hFF;
        hold(3);
        chk_zero("rst");
        reset = 1'b0;
        hold(5);

        // full frame 8765_4321
        p0 = pulses;
        for (int k = 0; k < 4; k++) pos(k, seg(k + 1, 0), seg(k + 5, 0), 100);
        chk("f1_pulses", pulses - p0, 1);
        chk("f1_hex", hex_val, 32'h8765_4321);
        chk("f1_ok", hex_ok, 8'hFF);
        chk("f1_dp", dpoints, 8'h00);
        chk("f1_fv", frame_valid, 1);
        blank(50);

        // invalid glyph with dp at k=1, glitch on the completing position
        p0 = pulses;
        pos(1, 8'h7F, seg(11, 0), 100);
        pos(2, seg(3, 0), seg(12, 1), 100);
        pos(3, seg(4, 0), seg(13, 0), 100);
        pos(0, seg(8, 0), seg(10, 0), 14);
        d2_seg = seg(1, 0);
        hold(100);
        chk("f2_pulses", pulses - p0, 1);
        chk("f2_hex", hex_val, 32'hDCBA_4301);
        chk("f2_ok", hex_ok, 8'hFD);
        chk("f2_dp", dpoints, 8'h42);
        blank(50);
        chk("blank_err", an_error, 0);

        // illegal anodes mid-frame
        p0 = pulses;
        pos(0, seg(1, 0), seg(5, 0), 100);
        pos(1, seg(2, 0), seg(6, 0), 100);
        d1_an = 4'b1110;
        d2_an = 4'b1101;
        hold(50);
        chk("ae_err", an_error, 1);
        pos(2, seg(3, 0), seg(7, 0), 100);
        chk("ae_nopub", pulses - p0, 0);
        pos(3, seg(4, 0), seg(8, 0), 100);
        chk("ae_pulses", pulses - p0, 1);
        chk("ae_hex", hex_val, 32'h8765_4321);
        blank(50);
        chk("ae_sticky", an_error, 1);

        // timeout
        blank(750);
        chk("st_early", stale, 0);
        chk("st_early_fv", frame_valid, 1);
        blank(300);
        chk("st_stale", stale, 1);
        chk("st_fv", frame_valid, 0);
        chk("st_hex", hex_val, 32'h8765_4321);
        p0 = pulses;
        pos(0, seg(0, 0), seg(5, 0), 100);
        chk("st_clear", stale, 0);
        chk("st_fv_off", frame_valid, 0);
        pos(1, seg(15, 0), seg(6, 0), 100);
        pos(2, seg(14, 0), seg(7, 0), 100);
        pos(3, seg(9, 0), seg(8, 0), 100);
        chk("st_pulses", pulses - p0, 1);
        chk("st_fv_back", frame_valid, 1);
        chk("st_hex2", hex_val, 32'h8765_9EF0);
        chk("st_ok2", hex_ok, 8'hFF);

        // reset mid-frame
        pos(0, seg(1, 0), seg(5, 0), 100);
        pos(1, seg(2, 0), seg(6, 0), 100);
        reset = 1'b1;
        d1_an = an(2);
        d2_an = an(2);
        d2_seg = seg(3, 0);
        d1_seg = seg(7, 0);
        hold(2);
        chk_zero("mid");
        reset = 1'b0;
        p0 = pulses;
        hold(100);
        pos(3, seg(4, 0), seg(8, 0), 100);
        chk("mid_nopub", pulses - p0, 0);
        chk("mid_hex", hex_val, 32'h0);
        chk("mid_fv", frame_valid, 0);
        pos(0, seg(1, 0), seg(5, 0), 100);
        chk("mid_nopub2", pulses - p0, 0);
        pos(1, seg(2, 0), seg(6, 0), 100);
        chk("mid_pulses", pulses - p0, 1);
        chk("mid_hex2", hex_val, 32'h8765_4321);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_capture.md
# sseg_scan_capture

Receive-side counterpart of the multiplexed seven-segment display drive. It samples the active-low anode/segment buses (D1_AN/D2_AN, D1_SEG/D2_SEG) and waits for each scan position to settle. It then reconstructs the eight displayed hex digits and decimal points, and publishes them atomically once per complete scan frame. It is used as an on-chip loopback checker for the display path and as a bench monitor.

## Interface
- SETTLE_CYCLES, default 16: consecutive unchanged cycles required before a scan position is sampled (must be ≥2)
- TIMEOUT_CYCLES, default 400_000: cycles without a valid sample before `stale` asserts
- clk  in  1  sampling clock
- reset  in  1  asynchronous, active-high
- D1_AN  in  4  left-display anodes, active-low one-cold
- D2_AN  in  4  right-display anodes, active-low one-cold
- D1_SEG  in  8  {dp_n, seg_n[6:0]} for digits 7..4, active-low
- D2_SEG  in  8  {dp_n, seg_n[6:0]} for digits 3..0, active-low
- hex_val  out  32  published digits, nibble k = digit k
- hex_ok  out  8  bit k = digit k matched a valid hex glyph
- dpoints  out  8  bit k = decimal point k lit (active-high)
- frame_valid  out  1  a complete frame has been published and `stale` is low
- frame_pulse  out  1  one-cycle strobe on each publish
- an_error  out  1  sticky: illegal anode pattern seen
- stale  out  1  no valid sample for TIMEOUT_CYCLES

## Operation
- **Synchronizer:** all 24 input bits pass through a 2-flop synchronizer. The synchronized bundle is B.
- **Settle counter:**
  - Compares B with its one-cycle-delayed copy.
  - Any difference resets the counter to 0.
  - Otherwise the counter increments, saturating at SETTLE_CYCLES.
  - Counter width is $clog2(SETTLE_CYCLES+1).
- **Sample strobe:** fires exactly once per stable window, in the cycle the counter reaches SETTLE_CYCLES−1 with B unchanged.
- **On sample, anode classification:**
  - D1_AN == D2_AN and exactly one bit is 0 at index k: valid, captured.
  - Both all-ones: blanking; ignored, no error, no timeout reset.
  - Any other pattern: set `an_error`; no capture.
- **Valid capture at index k:**
  - Shadow digit k is decoded from ~D2_SEG[6:0]; shadow digit k+4 is decoded from ~D1_SEG[6:0].
  - Shadow dp[k] = ~D2_SEG[7]; shadow dp[k+4] = ~D1_SEG[7].
  - Set `seen[k]`.
- **Glyph decode:** active-high {g..a} maps to a nibble.
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Any other pattern gives nibble 0 and ok 0.
- **Frame publish:**
  - When `seen` becomes 4'b1111 (any order), the shadow is copied to hex_val/hex_ok/dpoints.
  - `frame_pulse` asserts and `frame_valid` is set.
  - `seen` clears to 0 at the same edge.
- **Repeated index before frame completion:** overwrites the shadow entries; `seen` is unchanged.
- **Timeout counter:**
  - Clears on each valid capture and otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES: `stale` = 1, `frame_valid` = 0, `seen` cleared, published outputs held.
  - The next valid capture clears `stale`.
  - `frame_valid` returns only on the next publish.

## Timing
- **Reset (asynchronous):**
  - All outputs 0, including hex_val, hex_ok, dpoints, frame_valid, frame_pulse, an_error and stale.
  - Synchronizers, counters, `seen` and shadow registers cleared.
  - Reset mid-frame discards the partial frame.
- **Latency:**
  - A pin change first appears in B 2 edges later.
  - The sample strobe comes SETTLE_CYCLES−1 cycles after B first shows the new value (window held steady).
  - Shadow registers update on the following edge.
- **Publish:** hex_val, hex_ok, dpoints and `frame_pulse` all change on the edge after the strobe that completes `seen`. The pulse is exactly 1 cycle.
- **Glitch rejection:** a window shorter than SETTLE_CYCLES produces no sample. A bundle held indefinitely produces exactly one sample.
- `an_error` clears only on reset.
- **Strobe and timeout in the same cycle:** a valid capture wins, so `stale` stays 0.

## Test plan
- **Full frame:**
  - Stimulus: scan k=0..3 (AN one-cold at k), 100 cycles each. D2_SEG carries glyphs 1,2,3,4 and D1_SEG carries glyphs 5,6,7,8, all with dp_n=1.
  - Response: exactly one `frame_pulse`; hex_val=32'h8765_4321, hex_ok=8'hFF, dpoints=0, frame_valid=1.
- **Glitch rejection:**
  - Stimulus: during a stable position, change D2_SEG to glyph 8 for SETTLE_CYCLES−2 cycles, then restore glyph 1.
  - Response: published digit 0 = 1, not 8.
- **Invalid glyph and dp:**
  - Stimulus: at k=1, D2_SEG=8'h7F (dp lit, segments blank).
  - Response: after the frame, hex_ok[1]=0, nibble 1 = 0, dpoints[1]=1.
- **Anode error:**
  - Stimulus: D1_AN=4'b1110 with D2_AN=4'b1101, held stable.
  - Response: an_error=1 and remains 1; `seen` unchanged.
  - Stimulus: both AN=4'b1111.
  - Response: no error.
- **Stale:**
  - Stimulus: stop scanning for TIMEOUT_CYCLES (TIMEOUT_CYCLES=1000 in the bench).
  - Response: stale=1, frame_valid=0, hex_val held.
  - Stimulus: resume scanning.
  - Response: stale clears at the first capture; frame_valid returns after 4 positions.
- **Reset mid-frame:**
  - Stimulus: capture k=0,1; pulse reset; then scan k=2,3 only.
  - Response: all outputs 0 and no `frame_pulse` until k=0,1 are recaptured.
